// File: rtl/clk_div_sched_if.sv
// Control/status bundle between the user-facing run controls and the
// divided-clock scheduler. The master drives run requests and rate/burst
// settings; the slave (scheduler) drives the divided clock and status.
interface clk_div_sched_if;
    logic        start;
    logic        stop;
    logic [1:0]  rate_sel;
    logic [15:0] burst_len;
    logic        clk_out;
    logic        tick;
    logic        running;
    logic        done;
    logic [15:0] edge_count;

    modport master (
        output start, stop, rate_sel, burst_len,
        input  clk_out, tick, running, done, edge_count
    );

    modport slave (
        input  start, stop, rate_sel, burst_len,
        output clk_out, tick, running, done, edge_count
    );
endinterface

// File: rtl/clk_div_sched.sv
// Run controller and rate scheduler for the divided-clock datapath.
// A half-period counter toggles clk_out every N[active_sel] cycles of click.
// The rate select is only re-sampled at a half-period boundary, so clk_out
// never produces a short (glitch) phase. Supports continuous running and
// fixed-length bursts of clk_out toggles under start/stop control.
module clk_div_sched #(
    parameter int unsigned W  = 32,
    parameter int unsigned N0 = 100_000_000,
    parameter int unsigned N1 = 50_000_000,
    parameter int unsigned N2 = 1_000_000,
    parameter int unsigned N3 = 2
) (
    input  logic            click,
    input  logic            rst,
    clk_div_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] counter;
    logic [1:0]   active_sel;
    logic [15:0]  burst_reg;
    logic [W-1:0] half_limit;
    logic         boundary;
    logic [15:0]  edge_next;

    // Half-period length for a given rate select.
    function automatic logic [W-1:0] half_period(input logic [1:0] sel);
        case (sel)
            2'd0:    half_period = W'(N0);
            2'd1:    half_period = W'(N1);
            2'd2:    half_period = W'(N2);
            default: half_period = W'(N3);
        endcase
    endfunction

    // The boundary compare uses >= so a counter can never run past the limit.
    assign half_limit = half_period(active_sel) - W'(1);
    assign boundary   = (counter >= half_limit);
    assign edge_next  = bus.edge_count + 16'd1;

    // Status flags are decodes of the registered state, so they change on
    // the same edge as the state itself.
    assign bus.running = (state == S_RUN);
    assign bus.done    = (state == S_DONE);

    // Main sequencer: start/stop handling, half-period counting, toggling.
    always_ff @(posedge click) begin
        if (rst) begin
            state          <= S_IDLE;
            counter        <= '0;
            active_sel     <= 2'd0;
            burst_reg      <= 16'd0;
            bus.clk_out    <= 1'b0;
            bus.tick       <= 1'b0;
            bus.edge_count <= 16'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.stop) begin
                        // Stop beats a coincident boundary: no toggle, no count.
                        state       <= S_IDLE;
                        counter     <= '0;
                        bus.clk_out <= 1'b0;
                        bus.tick    <= 1'b0;
                    end else if (boundary) begin
                        counter        <= '0;
                        bus.clk_out    <= ~bus.clk_out;
                        bus.tick       <= 1'b1;
                        bus.edge_count <= edge_next;
                        active_sel     <= bus.rate_sel;
                        if ((burst_reg != 16'd0) && (edge_next == burst_reg)) begin
                            state <= S_DONE;
                        end
                    end else begin
                        counter  <= counter + W'(1);
                        bus.tick <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE: hold everything until a clean start.
                    bus.tick <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state          <= S_RUN;
                        active_sel     <= bus.rate_sel;
                        burst_reg      <= bus.burst_len;
                        counter        <= '0;
                        bus.clk_out    <= 1'b0;
                        bus.edge_count <= 16'd0;
                    end
                end
            endcase
        end
    end

endmodule
